// File: rtl/mpadder_modctrl.sv
// Modular add/subtract sequencer around the shared multi-precision adder.
// Issues one or two adder passes and returns (a +/- b) mod M.
module mpadder_modctrl #(
  parameter int unsigned N = 1027
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N-1:0] add_in_a,
  output logic [N-1:0] add_in_b,
  input  logic [N:0]   add_result,
  input  logic         add_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE1,
    S_WAIT1,
    S_ISSUE2,
    S_WAIT2,
    S_FIN
  } state_t;

  state_t       state_q, state_d;
  logic         op_q, op_d;
  logic [N-1:0] m_q, m_d;
  logic [N-1:0] t_q, t_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] result_q, result_d;
  logic         add_start_q, add_start_d;
  logic         add_sub_q, add_sub_d;
  logic [N-1:0] add_a_q, add_a_d;
  logic [N-1:0] add_b_q, add_b_d;

  // Adder operands are loaded on the edge that enters an ISSUE state, so
  // add_start and its operands appear together in that ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    m_d         = m_q;
    t_d         = t_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    add_start_d = 1'b0;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = subtract;
          m_d         = in_m;
          add_a_d     = in_a;
          add_b_d     = in_b;
          add_sub_d   = subtract;
          add_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ISSUE1;
        end
      end
      S_ISSUE1: state_d = S_WAIT1;
      S_WAIT1: begin
        if (add_done) begin
          t_d = add_result[N-1:0];
          if (op_q && !add_result[N]) begin
            // a-b already non-negative: no correction pass needed.
            result_d = add_result[N-1:0];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_FIN;
          end else begin
            add_a_d     = add_result[N-1:0];
            add_b_d     = m_q;
            add_sub_d   = ~op_q;
            add_start_d = 1'b1;
            state_d     = S_ISSUE2;
          end
        end
      end
      S_ISSUE2: state_d = S_WAIT2;
      S_WAIT2: begin
        if (add_done) begin
          if (op_q)
            result_d = add_result[N-1:0];
          else
            result_d = add_result[N] ? t_q : add_result[N-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      m_q         <= '0;
      t_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      m_q         <= m_d;
      t_q         <= t_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign add_start    = add_start_q;
  assign add_subtract = add_sub_q;
  assign add_in_a     = add_a_q;
  assign add_in_b     = add_b_q;

endmodule

// File: tb/tb_mpadder_modctrl.sv
// Bench for mpadder_modctrl with a behavioural adder of configurable latency.
module tb_mpadder_modctrl;
  localparam int N = 1027;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic         busy, done, add_start, add_subtract, add_done;
  logic [N-1:0] result, add_in_a, add_in_b;
  logic [N:0]   add_result;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  mpadder_modctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy), .done(done), .result(result),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Behavioural adder: add_done is high lat cycles after the add_start cycle.
  int unsigned  lat = 3;
  logic [7:0]   sr = '0;
  logic [N-1:0] ad_a = '0, ad_b = '0;
  logic         ad_sub = 1'b0;
  always @(posedge clk) begin
    sr <= {sr[6:0], add_start};
    if (add_start) begin
      ad_a   <= add_in_a;
      ad_b   <= add_in_b;
      ad_sub <= add_subtract;
    end
  end
  assign add_done = sr[lat-1];
  always_comb begin
    add_result = ad_sub ? ({1'b0, ad_a} - {1'b0, ad_b}) : ({1'b0, ad_a} + {1'b0, ad_b});
  end

  function automatic logic [N-1:0] ref_mod(input logic sub, input logic [N-1:0] a, b, m);
    logic [N+1:0] s;
    if (!sub) begin
      s = {2'b00, a} + {2'b00, b};
      if (s >= {2'b00, m}) s = s - {2'b00, m};
    end else if (a >= b) begin
      s = {2'b00, a} - {2'b00, b};
    end else begin
      s = {2'b00, m} - ({2'b00, b} - {2'b00, a});
    end
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_1024();
    logic [N-1:0] r = '0;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one request (start in cycle 0), samples #1 after each edge,
  // and pops/compares the scoreboard entry when done appears.
  task automatic run_op(input string name, input logic sub, input logic [N-1:0] a, b, m,
                        input logic [N-1:0] expv, input int ign1, input int ign2,
                        output int done_cyc, output int nst, output logic sub2,
                        output logic [N-1:0] b2, output logic busy_ok);
    logic [N-1:0] e;
    done_cyc = -1; nst = 0; sub2 = 1'bx; b2 = 'x; busy_ok = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == ign1 || k == ign2) begin
        start = 1'b1; subtract = ~sub; in_a = 5; in_b = 7; in_m = 11;
      end
      if (add_start) begin
        nst++;
        if (nst == 2) begin sub2 = add_subtract; b2 = add_in_b; end
      end
      if (done) begin
        done_cyc = k;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s timeout: done not seen, required within 99 cycles", name);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        errors++;
        $display("FAIL %s result: got %h required %h (low 128 bits)", name, result[127:0], e[127:0]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || add_start !== 1'b0 || add_subtract !== 1'b0 ||
        result !== '0 || add_in_a !== '0 || add_in_b !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b add_start=%b add_sub=%b result=%h a=%h b=%h, required all 0",
               name, busy, done, add_start, add_subtract, result[63:0], add_in_a[63:0], add_in_b[63:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_add_reduce();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    run_op("add_reduce", 1'b0, 50, 60, 97, 13, -1, -1, dc, ns, s2, b2, bok);
    checks++;
    if (dc !== 9 || ns !== 2 || s2 !== 1'b1 || b2 !== 97 || bok !== 1'b1) begin
      errors++;
      $display("FAIL add_reduce timing: done_cyc=%0d starts=%0d sub2=%b b2=%0d busy_ok=%b, required 9 2 1 97 1",
               dc, ns, s2, b2, bok);
    end
  endtask

  task automatic test_add_plain();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    run_op("add_plain", 1'b0, 10, 20, 97, 30, -1, -1, dc, ns, s2, b2, bok);
    checks++;
    if (dc !== 9 || ns !== 2) begin
      errors++;
      $display("FAIL add_plain timing: done_cyc=%0d starts=%0d, required 9 2", dc, ns);
    end
    run_op("add_eq_m", 1'b0, 47, 50, 97, 0, -1, -1, dc, ns, s2, b2, bok);
    run_op("add_max", 1'b0, 96, 96, 97, 95, -1, -1, dc, ns, s2, b2, bok);
  endtask

  task automatic test_sub();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    run_op("sub_neg", 1'b1, 20, 50, 97, 67, -1, -1, dc, ns, s2, b2, bok);
    checks++;
    if (dc !== 9 || ns !== 2 || s2 !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg timing: done_cyc=%0d starts=%0d sub2=%b, required 9 2 0", dc, ns, s2);
    end
    run_op("sub_pos", 1'b1, 50, 20, 97, 30, -1, -1, dc, ns, s2, b2, bok);
    checks++;
    if (dc !== 5 || ns !== 1 || bok !== 1'b1) begin
      errors++;
      $display("FAIL sub_pos timing: done_cyc=%0d starts=%0d busy_ok=%b, required 5 1 1", dc, ns, bok);
    end
  endtask

  task automatic test_ignore_start();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    run_op("ignore_start", 1'b0, 50, 60, 97, 13, 2, 6, dc, ns, s2, b2, bok);
    checks++;
    if (dc !== 9 || ns !== 2) begin
      errors++;
      $display("FAIL ignore_start timing: done_cyc=%0d starts=%0d, required 9 2", dc, ns);
    end
  endtask

  task automatic test_reset_mid();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    logic saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; subtract = 1'b0; in_a = 50; in_b = 60; in_m = 97;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      reset = (k == 6);
      if (k >= 7 && done === 1'b1) saw_done = 1'b1;
      if (k == 7 || k == 9 || k == 12) check_idle_outputs("reset_mid_outputs");
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid done: got done after reset, required none");
    end
    run_op("after_reset", 1'b0, 1, 2, 97, 3, -1, -1, dc, ns, s2, b2, bok);
  endtask

  task automatic test_start_with_reset();
    logic bad = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; reset = 1'b1; subtract = 1'b0; in_a = 50; in_b = 60; in_m = 97;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy !== 1'b0 || add_start !== 1'b0 || done !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL start_with_reset: request activity seen, required none");
    end
  endtask

  task automatic test_random();
    int dc, ns; logic s2, bok; logic [N-1:0] b2;
    logic [N-1:0] m, a, b;
    logic sub;
    logic bad_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(1, 5);
      m = rand_1024();
      m[1023] = 1'b1;
      a = rand_1024() % m;
      b = rand_1024() % m;
      if (i == 0) a = m - 1;
      if (i == 1) b = m - 1;
      sub = $urandom_range(0, 1);
      run_op("random", sub, a, b, m, ref_mod(sub, a, b, m), -1, -1, dc, ns, s2, b2, bok);
      if (bok !== 1'b1) bad_busy = 1'b1;
    end
    lat = 3;
    checks++;
    if (bad_busy !== 1'b0) begin
      errors++;
      $display("FAIL random busy: busy profile wrong in some vector, required high until done");
    end
  endtask

  initial begin
    test_reset();
    test_add_reduce();
    test_add_plain();
    test_sub();
    test_ignore_start();
    test_reset_mid();
    test_start_with_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpadder_modctrl.md
# mpadder_modctrl

Sequencer that turns the shared multi-precision adder (`mpadder`) into a modular adder/subtractor. Given operands a, b < M, it issues one or two add/sub passes to the adder and returns (a ± b) mod M. It sits between the Montgomery top-level control and the adder and owns the adder's start/subtract/operand ports.

## Interface

Parameters:
- `N`, 1027, operand width; the adder result is N+1 bits.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `subtract`  in  1  0: (a+b) mod M; 1: (a−b) mod M. Sampled with `start`.
- `in_a`, `in_b`, `in_m`  in  N each  operands and modulus, latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  N  modular result, held until the next accepted start.
- `add_start`  out  1  one-cycle start pulse to the adder.
- `add_subtract`  out  1  adder mode.
- `add_in_a`, `add_in_b`  out  N each  adder operands, held stable from `add_start` until `add_done`.
- `add_result`  in  N+1  adder result. Subtraction yields (x−y) mod 2^(N+1); bit N is set iff x<y.
- `add_done`  in  1  adder completion pulse; `add_result` is valid in the same cycle.

## Operation

- Preconditions: M < 2^(N−1) and a, b < M. Results are undefined otherwise and are not checked.
- Register states are IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2 and FIN.
- IDLE:
  - On `start`, latch a, b, M and the op, then go to ISSUE1.
  - `start` in any other state is ignored.
- ISSUE1:
  - Drive `add_start`=1, `add_in_a`=a, `add_in_b`=b, `add_subtract`=op.
  - Go to WAIT1.
- WAIT1:
  - On `add_done`, capture t = `add_result`.
  - Add: go to ISSUE2.
  - Sub with t[N]=0: load `result`=t[N−1:0], go to FIN.
  - Sub with t[N]=1: go to ISSUE2.
- ISSUE2:
  - Add: `add_in_a`=t[N−1:0], `add_in_b`=M, `add_subtract`=1.
  - Sub: `add_in_a`=t[N−1:0], `add_in_b`=M, `add_subtract`=0.
  - Pulse `add_start`, then go to WAIT2.
- WAIT2: on `add_done`, with u = `add_result`:
  - Add: `result` = u[N] ? t[N−1:0] : u[N−1:0].
  - Sub: `result` = u[N−1:0], since the 2^N wrap falls into bit N and is discarded.
  - Go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `add_done` is ignored in IDLE, ISSUE1, ISSUE2 and FIN.
- `add_in_a`, `add_in_b` and `add_subtract` are registered and change only when entering ISSUE1 or ISSUE2.

## Timing

- Reset values:
  - State is IDLE.
  - `busy`, `done`, `add_start` and `add_subtract` are 0.
  - `result`, `add_in_a` and `add_in_b` are 0.
- Timing reference: `start` is accepted at cycle 0. The adder raises `add_done` L cycles after its `add_start` cycle.
- Two-pass latency:
  - `add_start` is high in cycle 1.
  - `add_done` arrives in cycle 1+L; `add_start` is high again in cycle 2+L.
  - `add_done` arrives in cycle 2+2L; `done` is high in cycle 3+2L.
- One-pass latency (sub, non-negative): `done` is high in cycle 2+L.
- `busy` is high in cycles 1 through `done`-1 and low in the `done` cycle.
- A new `start` is accepted in the cycle after `done` at the earliest.
- Reset mid-operation:
  - Return to IDLE immediately with all outputs at their reset values.
  - A late `add_done` from the aborted pass is ignored.
  - The next `start` proceeds normally, provided the adder has also been reset or has completed.
- `start` coincident with `reset`: reset wins and the request is dropped.

## Test plan

Use N=1027, M=97 and a behavioural adder with L=3 unless stated otherwise.

- Add with reduction, a=50, b=60 → `result`=13. `done` in cycle 9, two `add_start` pulses, second pass has `add_subtract`=1.
- Add without reduction, a=10, b=20 → 30. Add boundaries:
  - a=47, b=50 → 0 (a+b=M).
  - a=96, b=96 → 95.
- Subtract, negative path: a=20, b=50 → 67, with two passes and the second pass `add_subtract`=0. Subtract, non-negative path: a=50, b=20 → 30, with one `add_start`, `done` in cycle 5 and `busy` high in cycles 1–4.
- `start` pulsed with a different operand set in cycles 2 and 6 of a running add → ignored. The first result is unchanged and exactly two `add_start` pulses are seen.
- `reset` asserted in the WAIT2 cycle, then `add_done` delivered afterwards → no `done`, all outputs 0, `busy` 0. A following a=1, b=2 add → 3.
- Real `mpadder` as the adder with a 1024-bit M and random a, b < M (both ops, 200 vectors) → matches a reference modular model.
